secded_check_encoder: RTL and testbench



---
 rtl/secded_check_encoder.sv | 131 +++++++++++++
 tb/tb_secded_check_encoder.sv | 467 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/secded_check_encoder.sv
// secded_check_encoder
// Write-side SEC-DED encoder: accepts 8-bit data words, computes four
// Hamming check bits plus overall parity, and presents the word through
// a two-stage registered pipeline to the storage write port.
//
// Check word layout: bits [4:1] are the syndrome-position bits and
// bit [0] is the overall parity, as the read-side comparator expects.
//
// A test-only injection path XORs an armed 13-bit mask into
// {data, check} of the next accepted word. Mask bits [12:5] hit the
// data and bits [4:0] hit the check word. Check bits are always
// computed from the clean data, so injected data errors become
// detectable.
module secded_check_encoder #(
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [7:0]        in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [7:0]        out_data,
    output logic [4:0]        out_check,
    input  logic              inj_arm,
    input  logic [12:0]       inj_mask,
    output logic              inj_pending,
    output logic [CNT_W-1:0]  word_count
);

    // Even-parity Hamming check bits followed by overall parity over data and check bits
    function automatic logic [4:0] calc_check(input logic [7:0] d);
        logic [4:1] c;
        c[1] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
        c[2] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
        c[3] = d[1] ^ d[2] ^ d[3] ^ d[7];
        c[4] = d[4] ^ d[5] ^ d[6] ^ d[7];
        return {c, (^d) ^ (^c)};
    endfunction

    logic              s1_valid;
    logic [ADDR_W-1:0] s1_addr;
    logic [7:0]        s1_data;
    logic [12:0]       s1_mask;
    logic [12:0]       armed_mask;

    logic              s2_free;
    logic              s1_advance;
    logic              accept;
    logic              drain;
    logic [12:0]       accept_mask;
    logic [12:0]       s2_word;

    // Handshake decode: S2 can take a word if empty or draining; no skid buffer, so in_ready follows out_ready combinationally
    always_comb begin
        drain       = out_valid && out_ready;
        s2_free     = !out_valid || out_ready;
        s1_advance  = s1_valid && s2_free;
        in_ready    = !reset && (!s1_valid || s1_advance);
        accept      = in_valid && in_ready;
        accept_mask = 13'd0;
        if (inj_arm) begin
            accept_mask = inj_mask;
        end else if (inj_pending) begin
            accept_mask = armed_mask;
        end
        s2_word = {s1_data, calc_check(s1_data)} ^ s1_mask;
    end

    // Injection arming: a new arm wins over an older one, and an accept consumes whatever mask applies to that word
    always_ff @(posedge clk) begin
        if (reset) begin
            inj_pending <= 1'b0;
            armed_mask  <= 13'd0;
        end else if (accept) begin
            inj_pending <= 1'b0;
            armed_mask  <= 13'd0;
        end else if (inj_arm) begin
            inj_pending <= 1'b1;
            armed_mask  <= inj_mask;
        end
    end

    // Stage 1: capture the accepted word and the mask it carries; empties when it moves into stage 2
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_addr  <= '0;
            s1_data  <= 8'd0;
            s1_mask  <= 13'd0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_addr  <= in_addr;
            s1_data  <= in_data;
            s1_mask  <= accept_mask;
        end else if (s1_advance) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: encoded word register feeding storage; holds steady while storage stalls
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= 8'd0;
            out_check <= 5'd0;
        end else if (s1_advance) begin
            out_valid <= 1'b1;
            out_addr  <= s1_addr;
            out_data  <= s2_word[12:5];
            out_check <= s2_word[4:0];
        end else if (drain) begin
            out_valid <= 1'b0;
        end
    end

    // Delivered-word counter, sticks at all-ones
    always_ff @(posedge clk) begin
        if (reset) begin
            word_count <= '0;
        end else if (drain && (word_count != {CNT_W{1'b1}})) begin
            word_count <= word_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_secded_check_encoder.sv
// Self-checking bench for secded_check_encoder: directed scenarios plus a
// randomized run scored against a Hamming-position reference model.
module tb_secded_check_encoder;

    typedef logic [16:0] word_t;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_addr;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_addr;
    logic [7:0]  out_data;
    logic [4:0]  out_check;
    logic        inj_arm;
    logic [12:0] inj_mask;
    logic        inj_pending;
    logic [15:0] word_count;

    logic        in_ready4;
    logic        out_valid4;
    logic [3:0]  out_addr4;
    logic [7:0]  out_data4;
    logic [4:0]  out_check4;
    logic        inj_pending4;
    logic [3:0]  word_count4;

    int tests_run = 0;
    int fails = 0;

    word_t exp_q[$];
    word_t got_q[$];
    logic        m_pending;
    logic [12:0] m_mask;
    int          delivered;

    secded_check_encoder #(.ADDR_W(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_data(out_data), .out_check(out_check),
        .inj_arm(inj_arm), .inj_mask(inj_mask), .inj_pending(inj_pending),
        .word_count(word_count)
    );

    secded_check_encoder #(.ADDR_W(4), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready4), .in_addr(in_addr), .in_data(in_data),
        .out_valid(out_valid4), .out_ready(out_ready), .out_addr(out_addr4),
        .out_data(out_data4), .out_check(out_check4),
        .inj_arm(inj_arm), .inj_mask(inj_mask), .inj_pending(inj_pending4),
        .word_count(word_count4)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference check word: data bits sit at Hamming positions 3,5,6,7,9,10,11,12;
    // check bit k covers every position with bit k-1 set; bit 0 is overall parity
    function automatic logic [4:0] model_check(input logic [7:0] d);
        int pos [8];
        logic [4:0] c;
        pos = '{3, 5, 6, 7, 9, 10, 11, 12};
        c = 5'd0;
        for (int i = 0; i < 8; i++) begin
            if (d[i]) begin
                for (int k = 1; k <= 4; k++) begin
                    if (pos[i][k-1]) c[k] = ~c[k];
                end
            end
        end
        c[0] = ^{d, c[4:1]};
        return c;
    endfunction

    // Scoreboard monitor: samples handshakes mid-cycle, predicts each accepted word and records each delivered word
    always @(negedge clk) begin
        logic [12:0] mask;
        if (reset) begin
            exp_q.delete();
            got_q.delete();
            m_pending = 1'b0;
            m_mask    = 13'd0;
            delivered = 0;
        end else begin
            if (out_valid && out_ready) begin
                got_q.push_back({out_addr, out_data, out_check});
                delivered++;
            end
            if (in_valid && in_ready) begin
                mask = inj_arm ? inj_mask : (m_pending ? m_mask : 13'd0);
                m_pending = 1'b0;
                exp_q.push_back({in_addr, {in_data, model_check(in_data)} ^ mask});
            end else if (inj_arm) begin
                m_mask    = inj_mask;
                m_pending = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        inj_arm = 1'b0;
        inj_mask = 13'd0;
        out_ready = 1'b0;
        in_data = 8'd0;
        in_addr = 4'd0;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        tests_run++;
        if ({in_ready, out_valid, out_addr, out_data, out_check, inj_pending, word_count} !== 36'd0) begin
            fails++;
            $display("[TB] FAIL reset_state: got rdy=%b v=%b a=%h d=%h c=%b p=%b cnt=%0d required all zero",
                     in_ready, out_valid, out_addr, out_data, out_check, inj_pending, word_count);
        end
        reset = 1'b0;
        in_valid = 1'b0;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL ready_after_reset: got %b required 1", in_ready);
        end
    endtask

    task automatic test_basic();
        logic [7:0] vec [4];
        logic [4:0] chk [4];
        vec = '{8'h00, 8'h01, 8'hFF, 8'h80};
        chk = '{5'b00000, 5'b00111, 5'b00110, 5'b11001};
        do_reset();
        out_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            if (n < 4) begin
                in_valid = 1'b1;
                in_data  = vec[n];
                in_addr  = 4'(n);
                #1;
                tests_run++;
                if (in_ready !== 1'b1) begin
                    fails++;
                    $display("[TB] FAIL basic_ready[%0d]: got %b required 1", n, in_ready);
                end
            end else begin
                in_valid = 1'b0;
            end
            tick();
            tests_run++;
            if (n >= 1 && n <= 4) begin
                if (out_valid !== 1'b1 || out_data !== vec[n-1] || out_check !== chk[n-1] || out_addr !== 4'(n-1)) begin
                    fails++;
                    $display("[TB] FAIL basic_word[%0d]: got v=%b a=%h d=%h c=%b required v=1 a=%h d=%h c=%b",
                             n-1, out_valid, out_addr, out_data, out_check, 4'(n-1), vec[n-1], chk[n-1]);
                end
            end else if (out_valid !== 1'b0) begin
                fails++;
                $display("[TB] FAIL basic_idle[%0d]: got out_valid=%b required 0", n, out_valid);
            end
        end
        tests_run++;
        if (word_count !== 16'd4) begin
            fails++;
            $display("[TB] FAIL basic_count: got %0d required 4", word_count);
        end
    endtask

    task automatic test_stall();
        logic [7:0] sv [3];
        int idx;
        logic acc;
        logic [16:0] snap;
        int budget;
        sv = '{8'h3C, 8'hA5, 8'h5A};
        do_reset();
        idx = 0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            in_valid = (idx < 3);
            if (idx < 3) begin
                in_data = sv[idx];
                in_addr = 4'(idx + 1);
            end
            #1;
            acc = in_valid && in_ready;
            tick();
            if (acc) idx++;
        end
        tests_run++;
        if (in_ready !== 1'b0 || idx != 2 || out_valid !== 1'b1) begin
            fails++;
            $display("[TB] FAIL stall_full: got in_ready=%b accepted=%0d out_valid=%b required 0/2/1",
                     in_ready, idx, out_valid);
        end
        snap = {out_addr, out_data, out_check};
        for (int h = 0; h < 5; h++) begin
            tick();
            tests_run++;
            if (out_valid !== 1'b1 || {out_addr, out_data, out_check} !== snap || in_ready !== 1'b0) begin
                fails++;
                $display("[TB] FAIL stall_hold[%0d]: got v=%b word=%h rdy=%b required v=1 word=%h rdy=0",
                         h, out_valid, {out_addr, out_data, out_check}, in_ready, snap);
            end
        end
        out_ready = 1'b1;
        budget = 0;
        while ((idx < 3 || out_valid) && budget < 20) begin
            in_valid = (idx < 3);
            if (idx < 3) begin
                in_data = sv[idx];
                in_addr = 4'(idx + 1);
            end
            #1;
            acc = in_valid && in_ready;
            tick();
            if (acc) idx++;
            budget++;
        end
        in_valid = 1'b0;
        tests_run++;
        if (budget >= 20 || got_q.size() != 3) begin
            fails++;
            $display("[TB] FAIL stall_release: got %0d words (budget %0d) required 3", got_q.size(), budget);
        end else begin
            for (int i = 0; i < 3; i++) begin
                tests_run++;
                if (got_q[i] !== {4'(i + 1), sv[i], model_check(sv[i])}) begin
                    fails++;
                    $display("[TB] FAIL stall_order[%0d]: got %h required %h",
                             i, got_q[i], {4'(i + 1), sv[i], model_check(sv[i])});
                end
            end
        end
    endtask

    task automatic test_injection();
        int          mode [6];
        logic [12:0] mk [6];
        logic [7:0]  dt [6];
        logic [7:0]  ed [6];
        logic [4:0]  ec [6];
        mode = '{1, 0, 1, 2, 1, 3};
        mk   = '{13'h0001, 13'h0000, 13'h0060, 13'h0006, 13'h0020, 13'h0020};
        dt   = '{8'h01, 8'h01, 8'hFF, 8'hFF, 8'h00, 8'h00};
        ed   = '{8'h01, 8'h01, 8'hFC, 8'hFF, 8'h01, 8'h01};
        ec   = '{5'b00110, 5'b00111, 5'b00110, 5'b00000, 5'b00000, 5'b00000};
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (mode[i] == 1 || mode[i] == 3) begin
                if (mode[i] == 3) begin
                    inj_arm = 1'b1;
                    inj_mask = 13'h1FFF;
                    tick();
                end
                inj_arm = 1'b1;
                inj_mask = mk[i];
                tick();
                inj_arm = 1'b0;
                tests_run++;
                if (inj_pending !== 1'b1) begin
                    fails++;
                    $display("[TB] FAIL inj_armed[%0d]: got %b required 1", i, inj_pending);
                end
            end
            in_valid = 1'b1;
            in_data  = dt[i];
            in_addr  = 4'(i);
            inj_arm  = (mode[i] == 2);
            inj_mask = mk[i];
            tick();
            in_valid = 1'b0;
            inj_arm  = 1'b0;
            tests_run++;
            if (inj_pending !== 1'b0) begin
                fails++;
                $display("[TB] FAIL inj_consumed[%0d]: got %b required 0", i, inj_pending);
            end
            tick();
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== ed[i] || out_check !== ec[i] || out_addr !== 4'(i)) begin
                fails++;
                $display("[TB] FAIL inj_word[%0d]: got v=%b a=%h d=%h c=%b required v=1 a=%h d=%h c=%b",
                         i, out_valid, out_addr, out_data, out_check, 4'(i), ed[i], ec[i]);
            end
            tick();
        end
    endtask

    task automatic test_reset_flush();
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h11;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h22;
        tick();
        in_data = 8'h33;
        tick();
        in_valid = 1'b0;
        inj_arm = 1'b1;
        inj_mask = 13'h0101;
        tick();
        inj_arm = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || inj_pending !== 1'b1 || word_count !== 16'd1) begin
            fails++;
            $display("[TB] FAIL flush_setup: got v=%b p=%b cnt=%0d required 1/1/1", out_valid, inj_pending, word_count);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        tests_run++;
        if (out_valid !== 1'b0 || inj_pending !== 1'b0 || word_count !== 16'd0) begin
            fails++;
            $display("[TB] FAIL flush_state: got v=%b p=%b cnt=%0d required 0/0/0", out_valid, inj_pending, word_count);
        end
        for (int c = 0; c < 5; c++) tick();
        tests_run++;
        if (got_q.size() != 0 || word_count !== 16'd0) begin
            fails++;
            $display("[TB] FAIL flush_nothing_emitted: got %0d words cnt=%0d required 0/0", got_q.size(), word_count);
        end
    endtask

    task automatic test_random();
        logic stall;
        logic [16:0] snap;
        int budget;
        int errs;
        do_reset();
        errs = 0;
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            in_addr   = 4'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            inj_arm   = ($urandom_range(0, 9) == 0);
            inj_mask  = 13'($urandom);
            #1;
            stall = out_valid && !out_ready;
            snap  = {out_addr, out_data, out_check};
            tick();
            if (stall) begin
                tests_run++;
                if (out_valid !== 1'b1 || {out_addr, out_data, out_check} !== snap) begin
                    fails++;
                    $display("[TB] FAIL rand_stall_hold[%0d]: got v=%b word=%h required v=1 word=%h",
                             c, out_valid, {out_addr, out_data, out_check}, snap);
                end
            end
            tests_run++;
            if (inj_pending !== m_pending) begin
                fails++;
                $display("[TB] FAIL rand_pending[%0d]: got %b required %b", c, inj_pending, m_pending);
            end
        end
        in_valid = 1'b0;
        inj_arm = 1'b0;
        out_ready = 1'b1;
        budget = 0;
        while (out_valid && budget < 10) begin
            tick();
            budget++;
        end
        tick();
        tests_run++;
        if (got_q.size() != exp_q.size() || got_q.size() == 0) begin
            fails++;
            $display("[TB] FAIL rand_word_total: got %0d required %0d (nonzero)", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < got_q.size(); i++) begin
                if (got_q[i] !== exp_q[i]) begin
                    errs++;
                    if (errs <= 5) $display("[TB] FAIL rand_word[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
                end
            end
            tests_run++;
            if (errs != 0) begin
                fails++;
                $display("[TB] FAIL rand_words: got %0d differing words required 0", errs);
            end
        end
        tests_run++;
        if (word_count !== 16'(delivered)) begin
            fails++;
            $display("[TB] FAIL rand_count: got %0d required %0d", word_count, delivered);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 14; i++) begin
            in_data = 8'(i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        tests_run++;
        if (word_count4 !== 4'hE) begin
            fails++;
            $display("[TB] FAIL sat_pre: got %h required e", word_count4);
        end
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        tests_run++;
        if (word_count4 !== 4'hF || word_count !== 16'd17) begin
            fails++;
            $display("[TB] FAIL sat_stick: got cnt4=%h cnt16=%0d required f/17", word_count4, word_count);
        end
    endtask

    // Scenario sequence and summary
    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        in_data = 8'd0;
        in_addr = 4'd0;
        out_ready = 1'b0;
        inj_arm = 1'b0;
        inj_mask = 13'd0;
        test_reset();
        test_basic();
        test_stall();
        test_injection();
        test_reset_flush();
        test_random();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
